// File: rtl/spike_event_encoder.sv
// spike_event_encoder
//   Captures one parallel spike vector per timestep and serialises it into the
//   event FIFO: one word per set bit (ascending neuron index), then one
//   end-of-timestep marker word {1, ts_count}. Stalls on fifo_full so no
//   accepted event is ever lost.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   spike_valid     vector offer, sampled only while spike_ready=1
//   spike_vec       bit i = neuron i fired this timestep
//   spike_ready     idle, able to accept a vector
//   fifo_full       FIFO full flag (same-cycle)
//   fifo_wr_en      FIFO write strobe (state decode gated by fifo_full)
//   fifo_data       event word to the FIFO
//   busy            emitting events for a captured vector
//   ts_count        index of the next timestep marker
//   overrun         sticky: spike_valid seen while not ready
module spike_event_encoder #(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spike_valid,
  input  logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   spike_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   busy,
  output logic [DATA_WIDTH-2:0]  ts_count,
  output logic                   overrun
);

  localparam int unsigned TS_W  = DATA_WIDTH - 1;
  localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_MARK = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic                   overrun_q, overrun_d;

  logic [IDX_W-1:0]       low_idx;
  logic [NUM_NEURONS-1:0] pending_rest;

  // Lowest set bit of pending: scan downward so the lowest index wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end

  // x & (x-1) clears exactly the lowest set bit.
  assign pending_rest = pending_q & (pending_q - NUM_NEURONS'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      ts_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ts_q      <= ts_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state and write-port decode; the write uses this cycle's full flag.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ts_d       = ts_q;
    overrun_d  = overrun_q;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;

    if (spike_valid && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (spike_valid) begin
          pending_d = spike_vec;
          state_d   = (spike_vec != '0) ? ST_SCAN : ST_MARK;
        end
      end
      ST_SCAN: begin
        fifo_data = DATA_WIDTH'(low_idx);
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          pending_d  = pending_rest;
          if (pending_rest == '0) state_d = ST_MARK;
        end
      end
      ST_MARK: begin
        fifo_data = {1'b1, ts_q};
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          ts_d       = ts_q + TS_W'(1);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign spike_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign ts_count    = ts_q;
  assign overrun     = overrun_q;

endmodule
